// File: rtl/sqrt_share_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one combinational square-root core.
// Stage 1 registers the granted radicand; stage 2 registers the core result with its requester ID.
module sqrt_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IN_W-1:0]  req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [IN_W-1:0]        sqrt_r,
    input  logic [OUT_W-1:0]       sqrt_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_result,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid must not depend on ready, and data is held while valid && !ready.

    logic              s1_valid;
    logic [IN_W-1:0]   s1_data;
    logic [ID_W-1:0]   s1_id;
    logic [ID_W-1:0]   rr_ptr;

    logic              s2_adv;
    logic              s1_free;
    logic              any_req;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   probe_idx;
    logic              accept;
    int                probe;

    logic [IN_W-1:0]   req_word [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*IN_W +: IN_W];
    end

    assign s2_adv  = !out_valid || out_ready;
    assign s1_free = !s1_valid || s2_adv;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        probe     = 0;
        probe_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            probe = int'(rr_ptr) + k;
            if (probe >= N_REQ) begin
                probe = probe - N_REQ;
            end
            probe_idx = ID_W'(probe);
            if (!any_req && req_valid[probe_idx]) begin
                any_req   = 1'b1;
                grant_idx = probe_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && any_req && s1_free) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = any_req && s1_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= req_word[grant_idx];
            s1_id    <= grant_idx;
            rr_ptr   <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (s1_free) begin
            s1_valid <= 1'b0;
        end
    end

    // The core sees the stage-1 register, so sqrt_q is captured one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_id     <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= sqrt_q;
                out_id     <= s1_id;
            end
        end
    end

    assign sqrt_r = s1_data;
    assign busy   = s1_valid || out_valid;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Directed bench for sqrt_share_arbiter: root core stubbed as sqrt_r[15:8], results
// checked in order against a queue of hand-computed {id, root} pairs.
module tb_sqrt_share_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int W     = ID_W + OUT_W;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*IN_W-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic [IN_W-1:0]       sqrt_r;
    logic [OUT_W-1:0]      sqrt_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_result;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    sqrt_share_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .sqrt_r(sqrt_r),
        .sqrt_q(sqrt_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_id(out_id),
        .busy(busy)
    );

    assign sqrt_q = sqrt_r[15:8];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [IN_W-1:0] v);
        req_data[idx*IN_W +: IN_W] = v;
    endtask

    task automatic expect_result(input logic [ID_W-1:0] id, input logic [OUT_W-1:0] r);
        exp_q.push_back({id, r});
    endtask

    task automatic drain_and_check(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // scoreboard: pops on every output handshake
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {22'd0, out_id, out_result}, 32'h3ff);
            end else begin
                check("sb_result", {22'd0, out_id, out_result}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        out_ready = 1'b1;

        // reset state, with requests already raised
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_sqrt_r", sqrt_r, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_id", out_id, 0);
        req_valid = '0;
        rst_n     = 1'b1;

        // idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out_valid", out_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_sqrt_r", sqrt_r, 0);
            check("idle_req_ready", req_ready, 0);
        end

        // all four continuously requesting; first grant 0 shows rr_ptr held during idle
        set_word(0, 16'h1100);
        set_word(1, 16'h2200);
        set_word(2, 16'h3300);
        set_word(3, 16'h4400);
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            expect_result(ID_W'(i % 4), OUT_W'(8'h11 * ((i % 4) + 1)));
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_grant", req_ready, 32'(1 << (i % 4)));
            if (i >= 2) check("rr_throughput", out_valid, 1);
            @(negedge clk);
        end
        req_valid = '0;
        drain_and_check("rr");

        // single request from requester 1
        set_word(1, 16'h3F2A);
        req_valid = 4'b0010;
        expect_result(2'd1, 8'h3F);
        #1;
        check("single_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        check("single_sqrt_r", sqrt_r, 16'h3F2A);
        check("single_not_yet", out_valid, 0);
        @(negedge clk);
        check("single_out_valid", out_valid, 1);
        check("single_out_result", out_result, 8'h3F);
        check("single_out_id", out_id, 1);
        drain_and_check("single");

        // backpressure: rr_ptr is 2, requesters 0 and 2 pending, downstream stalled
        out_ready = 1'b0;
        set_word(0, 16'h5A00);
        set_word(2, 16'hA500);
        req_valid = 4'b0101;
        expect_result(2'd2, 8'hA5);
        expect_result(2'd0, 8'h5A);
        expect_result(2'd2, 8'hC3);
        #1;
        check("bp_grant_first", req_ready, 4'b0100);
        @(negedge clk);
        check("bp_grant_second", req_ready, 4'b0001);
        @(negedge clk);
        set_word(2, 16'hC300);
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_result", out_result, 8'hA5);
            check("bp_hold_id", out_id, 2);
            check("bp_hold_sqrt_r", sqrt_r, 16'h5A00);
            check("bp_hold_ready", req_ready, 0);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        drain_and_check("bp");

        // wrap: rr_ptr is 3, requesters 0 and 3 pending
        set_word(0, 16'h0F00);
        set_word(3, 16'hF000);
        req_valid = 4'b1001;
        expect_result(2'd3, 8'hF0);
        expect_result(2'd0, 8'h0F);
        expect_result(2'd3, 8'hF0);
        #1;
        check("wrap_grant_3", req_ready, 4'b1000);
        @(negedge clk);
        #1;
        check("wrap_grant_0", req_ready, 4'b0001);
        @(negedge clk);
        #1;
        check("wrap_grant_3_again", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        drain_and_check("wrap");

        // reset while both stages hold data; nothing may emerge afterwards
        out_ready = 1'b0;
        set_word(0, 16'h7700);
        req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        check("midrst_pre_out_valid", out_valid, 1);
        check("midrst_pre_sqrt_r", sqrt_r, 16'h7700);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_result", out_result, 0);
        check("midrst_out_id", out_id, 0);
        check("midrst_sqrt_r", sqrt_r, 0);
        check("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one combinational approximate square-root core (16-bit radicand in, 8-bit root out, MAHSQR k=14 family) among N_REQ requesters, e.g. parallel Sobel gradient-magnitude lanes.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registers the radicand into the core, then registers the core result with the requester ID.
- Produces one tagged result stream with backpressure and a throughput of one result per cycle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must be >= clog2(N_REQ).
- IN_W, 16, radicand width.
- OUT_W, 8, root width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_data  input  N_REQ*IN_W  packed radicands; requester i occupies bits [i*IN_W +: IN_W].
- req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
- sqrt_r  output  IN_W  radicand to the shared root core; driven from the stage-1 register.
- sqrt_q  input  OUT_W  root returned combinationally by the core for sqrt_r.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_result  output  OUT_W  root.
- out_id  output  ID_W  index of the requester that issued the radicand.
- busy  output  1  high when stage 1 or stage 2 holds data.

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - s1_valid=0, s1_data=0, s1_id=0, rr_ptr=0.
  - out_valid=0, out_result=0, out_id=0, busy=0.
  - req_ready=0 while reset is asserted.
- Pipeline control:
  - s2_adv = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_adv.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo N_REQ; the first set index g wins.
  - req_ready[g] = s1_free; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0.
- Accept: on a clock edge with req_valid[g] && req_ready[g]:
  - s1_data <= req_data[g], s1_id <= g, s1_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
  - rr_ptr is unchanged when nothing is accepted.
- Stage-1 drain: if s1_free and no accept, then s1_valid <= 0.
- sqrt_r = s1_data at all times; it stays stable while stage 1 is stalled.
- Stage 2, when s2_adv is high:
  - out_valid <= s1_valid.
  - If s1_valid: out_result <= sqrt_q and out_id <= s1_id.
- Stall: out_valid && !out_ready holds out_valid, out_result, out_id, s1_* and sqrt_r stable, and forces req_ready=0 when s1_valid=1.
- Latency: a request accepted at edge t appears with out_valid=1 at edge t+1 when stage 2 is free, i.e. the result is visible in the cycle after the accept. sqrt_q must settle within one cycle from the s1 register.
- Throughput: one accept and one result per cycle while out_ready=1.
- Fairness: a continuously requesting input waits at most N_REQ-1 accepts.
- Simultaneous events:
  - Accept and stage-2 drain in the same edge are legal; this is the full-throughput case.
  - An accept while out_valid && !out_ready is allowed only if s1_valid=0.
- busy = s1_valid || out_valid.
- Reset mid-operation discards all in-flight data; no result is emitted for it.
- Ordering: out_id/out_result pairs emerge in accept order; there is no reordering or data loss under any out_ready pattern.
- Widths: no arithmetic on the data path; the ID is zero-extended to ID_W.

Test Plan:
- Bench stub: sqrt_q = sqrt_r[15:8] so results are deterministic.
- Single request: req_valid=4'b0010 with req_data[1]=16'h3F2A for one handshake.
  -> req_ready=4'b0010; one cycle later out_valid=1, out_result=8'h3F, out_id=1.
- All four valid, continuous, out_ready=1:
  - Radicands 16'h1100, 16'h2200, 16'h3300, 16'h4400.
  -> Accepts in order 0,1,2,3,0,...; results 11,22,33,44 in that order; one per cycle.
- Backpressure: out_ready=0 for 5 cycles with two requests pending.
  -> out_valid stays 1 with values held; stage 1 fills; req_ready=0 until out_ready returns.
  -> Both results then emerge in order with none dropped.
- Round-robin wrap: rr_ptr=3 and req_valid=4'b1001.
  -> Grant goes to 3, then to 0, then back to 3.
  -> Requester 0 is never starved.
- Reset mid-flight: assert rst_n=0 while s1_valid=1 and out_valid=1.
  -> All outputs go to 0 immediately (asynchronously); after release, no stale result appears.
- Idle: req_valid=0 for 10 cycles after reset.
  -> out_valid=0, busy=0, sqrt_r=16'h0000, rr_ptr unchanged.
